// File: rtl/spectrogram_capture_if.sv
// Magnitude-spectrum stream into the capture buffer: one bin per beat, tlast on the last bin of a frame.
interface spectrogram_capture_if #(
    parameter int DataWidth = 16
) ();
    logic [DataWidth-1:0] in_data;
    logic                 in_last;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, in_last, in_valid, input in_ready);
    modport slave  (input in_data, in_last, in_valid, output in_ready);
endinterface

// File: rtl/spectrogram_capture.sv
// Frame-aligned capture of NFRAMES spectra into a dual-port RAM, held until the reader releases it.
// Bin b of frame f lives at address f*NBINS+b; the read port is free-running with one cycle of latency.
module spectrogram_capture #(
    parameter int DataWidth = 16,
    parameter int NBINS     = 257,
    parameter int NFRAMES   = 97,
    localparam int AddrWidth = $clog2(NBINS*NFRAMES),
    localparam int FcntWidth = $clog2(NFRAMES+1),
    localparam int BcntWidth = $clog2(NBINS+1)
) (
    input  logic                 clk,
    input  logic                 arstn,
    spectrogram_capture_if.slave s_in,
    input  logic                 start,
    input  logic                 release_i,
    output logic                 active,
    output logic                 done,
    output logic [FcntWidth-1:0] frame_cnt,
    output logic                 len_err,
    input  logic                 rd_en,
    input  logic [AddrWidth-1:0] rd_addr,
    output logic [DataWidth-1:0] rd_data,
    output logic                 rd_valid
);
    localparam int Depth = NBINS*NFRAMES;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FULL} state_e;

    state_e               state_q, state_d;
    logic [BcntWidth-1:0] bin_cnt_q, bin_cnt_d;
    logic [AddrWidth-1:0] wr_base_q, wr_base_d;
    logic [FcntWidth-1:0] frame_cnt_q, frame_cnt_d;
    logic                 len_err_q, len_err_d;
    logic [DataWidth-1:0] rd_data_q;
    logic                 rd_valid_q;
    logic [DataWidth-1:0] mem_q [Depth];

    logic                 accept, cap_beat, frame_ok, commit, last_commit;
    logic                 short_end, overlen, we;
    logic [AddrWidth-1:0] waddr;

    // in_ready depends on state only, so accept never loops through the stream source
    assign accept      = s_in.in_valid && (state_q != FULL);
    assign cap_beat    = accept && (state_q == CAPTURE ||
                                    (state_q == ARMED && bin_cnt_q == '0));
    assign frame_ok    = bin_cnt_q >= BcntWidth'(NBINS-1);
    assign commit      = cap_beat && s_in.in_last && frame_ok;
    assign last_commit = commit && (frame_cnt_q == FcntWidth'(NFRAMES-1));
    assign short_end   = cap_beat && s_in.in_last && !frame_ok;
    // length faults only matter for frames being captured; IDLE/ARMED discards are not judged
    assign overlen     = cap_beat && ((bin_cnt_q == BcntWidth'(NBINS-1) && !s_in.in_last) ||
                                      bin_cnt_q >= BcntWidth'(NBINS));
    assign waddr       = wr_base_q + AddrWidth'(bin_cnt_q);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:           if (start) state_d = ARMED;
            ARMED, CAPTURE: if (last_commit) state_d = FULL;
                            else if (cap_beat) state_d = CAPTURE;
            FULL:           if (release_i) state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_comb begin
        s_in.in_ready = (state_q != FULL);
        active        = (state_q == ARMED) || (state_q == CAPTURE);
        done          = (state_q == FULL);
        we            = cap_beat && (bin_cnt_q < BcntWidth'(NBINS));
    end

    always_comb begin
        bin_cnt_d   = bin_cnt_q;
        wr_base_d   = wr_base_q;
        frame_cnt_d = frame_cnt_q;
        len_err_d   = len_err_q;
        if (accept) begin
            if (s_in.in_last)                          bin_cnt_d = '0;
            else if (bin_cnt_q != BcntWidth'(NBINS))   bin_cnt_d = bin_cnt_q + BcntWidth'(1);
        end
        if (state_q == IDLE && start) begin
            wr_base_d   = '0;
            frame_cnt_d = '0;
            len_err_d   = 1'b0;
        end else begin
            if (commit) begin
                wr_base_d   = wr_base_q + AddrWidth'(NBINS);
                frame_cnt_d = frame_cnt_q + FcntWidth'(1);
            end
            if (short_end || overlen) len_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            bin_cnt_q   <= '0;
            wr_base_q   <= '0;
            frame_cnt_q <= '0;
            len_err_q   <= 1'b0;
        end else begin
            bin_cnt_q   <= bin_cnt_d;
            wr_base_q   <= wr_base_d;
            frame_cnt_q <= frame_cnt_d;
            len_err_q   <= len_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= s_in.in_data;
    end

    // read-before-write: a same-address write in this cycle is not visible yet
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= mem_q[rd_addr];
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign len_err   = len_err_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
endmodule
